// File: rtl/dir_cmd_pkg.sv
// Shared types and constants for the direction-command encoder.
package dir_cmd_pkg;

    // 2-bit direction codes stored in the press queue
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // ASCII bytes emitted on the output stream
    localparam logic [7:0] ASC_W   = 8'h77;
    localparam logic [7:0] ASC_S   = 8'h73;
    localparam logic [7:0] ASC_A   = 8'h61;
    localparam logic [7:0] ASC_D   = 8'h64;
    localparam logic [7:0] ASC_SEP = 8'h2C;

    // Output serializer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_CHAR = 2'd1,
        ST_SEND_SEP  = 2'd2
    } state_e;

    // Map a queued direction to its ASCII character
    function automatic logic [7:0] dir_to_ascii(input dir_e dir);
        case (dir)
            DIR_UP:   dir_to_ascii = ASC_W;
            DIR_DOWN: dir_to_ascii = ASC_S;
            DIR_LEFT: dir_to_ascii = ASC_A;
            default:  dir_to_ascii = ASC_D;
        endcase
    endfunction

endpackage

// File: rtl/dir_cmd_encoder_btn_debounce.sv
// One push-button: 2-FF synchronizer, debounce counter and press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          state_q, state_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Debounced state changes only once the counter has seen the full run of
    // differing samples; any sample matching the state restarts the run.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync2_q != state_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                state_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, debounce state and the delayed copy used for edge detect
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            prev_q  <= state_q;
            cnt_q   <= cnt_d;
        end
    end

    // Single-cycle pulse on the debounced rising edge only
    assign press_o = state_q & ~prev_q;

endmodule

// File: rtl/dir_cmd_encoder.sv
// Buttons -> debounced press events -> direction queue -> "<char>," byte stream.
module dir_cmd_encoder
    import dir_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          enable,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          press_up, press_down, press_left, press_right;
    logic          push_req, push, pop, full, empty;
    dir_e          push_dir;
    dir_e          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .rst(rst), .btn_i(btn_up),    .press_o(press_up));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .rst(rst), .btn_i(btn_down),  .press_o(press_down));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .rst(rst), .btn_i(btn_left),  .press_o(press_left));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .rst(rst), .btn_i(btn_right), .press_o(press_right));

    // Pick one press per cycle, up > down > left > right
    always_comb begin
        push_dir = DIR_RIGHT;
        if (press_up)        push_dir = DIR_UP;
        else if (press_down) push_dir = DIR_DOWN;
        else if (press_left) push_dir = DIR_LEFT;
    end

    assign push_req = enable & (press_up | press_down | press_left | press_right);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = (state_q == ST_SEND_CHAR) && out_ready;
    // A full queue still takes a press when the head leaves in the same cycle
    assign push     = push_req && (!full || pop);

    // Queue storage
    // NOTE: the data array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dir;
    end

    // Queue pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Serializer next state: char, then separator, chaining straight into the next char
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_SEND_CHAR;
                    data_d  = dir_to_ascii(mem_q[rd_ptr_q]);
                end
            end
            ST_SEND_CHAR: begin
                if (out_ready) begin
                    state_d = ST_SEND_SEP;
                    data_d  = ASC_SEP;
                end
            end
            ST_SEND_SEP: begin
                if (out_ready) begin
                    if (!empty) begin
                        state_d = ST_SEND_CHAR;
                        data_d  = dir_to_ascii(mem_q[rd_ptr_q]);
                    end else begin
                        state_d = ST_IDLE;
                        data_d  = 8'h00;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = 8'h00;
            end
        endcase
    end

    // Serializer state and output byte register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid  = (state_q != ST_IDLE);
    assign out_data   = data_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_dir_cmd_encoder.sv
// Directed bench for dir_cmd_encoder with a short debounce window.
module tb_dir_cmd_encoder;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       enable, out_ready;
    logic [7:0] out_data;
    logic       out_valid, overflow;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;

    dir_cmd_encoder #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .enable(enable),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold one button long enough to register, then long enough to release
    task automatic press(input int which);
        case (which)
            0: btn_up    = 1'b1;
            1: btn_down  = 1'b1;
            2: btn_left  = 1'b1;
            default: btn_right = 1'b1;
        endcase
        settle(8);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        settle(10);
    endtask

    initial begin
        rst = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        enable = 1'b1; out_ready = 1'b1;
        settle(3);
        check("rst_valid",    {31'd0, out_valid}, 32'd0);
        check("rst_data",     {24'd0, out_data},  32'h00);
        check("rst_count",    {29'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow},  32'd0);
        rst = 1'b0;
        tick();

        // 1: single up press, valid 8 edges after the first sampling edge
        btn_up = 1'b1;
        settle(8);
        check("t1_pre_valid", {31'd0, out_valid}, 32'd0);
        check("t1_count1",    {29'd0, fifo_count}, 32'd1);
        tick();
        check("t1_valid",     {31'd0, out_valid}, 32'd1);
        check("t1_char",      {24'd0, out_data},  32'h77);
        tick();
        check("t1_sep",       {24'd0, out_data},  32'h2C);
        check("t1_count0",    {29'd0, fifo_count}, 32'd0);
        btn_up = 1'b0;
        tick();
        check("t1_idle",      {31'd0, out_valid}, 32'd0);
        check("t1_idle_data", {24'd0, out_data},  32'h00);
        settle(12);
        check("t1_release",   {31'd0, out_valid}, 32'd0);

        // 2: 3-cycle glitch must not register
        btn_left = 1'b1;
        settle(3);
        btn_left = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t2_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check("t2_count", {29'd0, fifo_count}, 32'd0);

        // 3: stalled consumer, five presses into a depth-4 queue
        out_ready = 1'b0;
        press(1); press(2); press(3); press(0);
        check("t3_count4",   {29'd0, fifo_count}, 32'd4);
        check("t3_no_ovf",   {31'd0, overflow},   32'd0);
        press(1);
        check("t3_ovf",      {31'd0, overflow},   32'd1);
        check("t3_count4b",  {29'd0, fifo_count}, 32'd4);
        check("t3_head",     {24'd0, out_data},   32'h73);
        check("t3_head_vld", {31'd0, out_valid},  32'd1);
        out_ready = 1'b1;
        begin
            logic [7:0] exp_bytes [7];
            exp_bytes = '{8'h2C, 8'h61, 8'h2C, 8'h64, 8'h2C, 8'h77, 8'h2C};
            for (int i = 0; i < 7; i++) begin
                tick();
                check("t3_stream_vld", {31'd0, out_valid}, 32'd1);
                check("t3_stream",     {24'd0, out_data},  {24'd0, exp_bytes[i]});
            end
        end
        tick();
        check("t3_end_vld",  {31'd0, out_valid},  32'd0);
        check("t3_end_cnt",  {29'd0, fifo_count}, 32'd0);
        check("t3_ovf_held", {31'd0, overflow},   32'd1);

        // 4: simultaneous up+right, only up is queued
        btn_up = 1'b1; btn_right = 1'b1;
        wait_valid("t4_wait");
        check("t4_char", {24'd0, out_data}, 32'h77);
        tick();
        check("t4_sep",  {24'd0, out_data}, 32'h2C);
        tick();
        check("t4_idle", {31'd0, out_valid},  32'd0);
        check("t4_cnt",  {29'd0, fifo_count}, 32'd0);
        btn_up = 1'b0; btn_right = 1'b0;
        settle(12);
        check("t4_quiet", {31'd0, out_valid}, 32'd0);

        // 5: stalled output holds stable, then reset mid-pair
        out_ready = 1'b0;
        btn_left = 1'b1;
        wait_valid("t5_wait");
        check("t5_char", {24'd0, out_data}, 32'h61);
        btn_left = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_vld",  {31'd0, out_valid}, 32'd1);
            check("t5_hold_data", {24'd0, out_data},  32'h61);
        end
        check("t5_cnt1", {29'd0, fifo_count}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_vld",  {31'd0, out_valid},  32'd0);
        check("t5_rst_data", {24'd0, out_data},   32'h00);
        check("t5_rst_cnt",  {29'd0, fifo_count}, 32'd0);
        check("t5_rst_ovf",  {31'd0, overflow},   32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        settle(12);
        check("t5_no_resume", {31'd0, out_valid}, 32'd0);

        // 6: disabled presses are discarded without overflow
        enable = 1'b0;
        press(3);
        check("t6_off_vld", {31'd0, out_valid},  32'd0);
        check("t6_off_ovf", {31'd0, overflow},   32'd0);
        check("t6_off_cnt", {29'd0, fifo_count}, 32'd0);
        enable = 1'b1;
        btn_right = 1'b1;
        wait_valid("t6_wait");
        check("t6_char", {24'd0, out_data}, 32'h64);
        tick();
        check("t6_sep",  {24'd0, out_data}, 32'h2C);
        tick();
        check("t6_idle", {31'd0, out_valid}, 32'd0);
        btn_right = 1'b0;
        settle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
